// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory access unit: request sizes, FSM states
// and the alignment rule used when a request is accepted.
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_READ     = 3'd1,
        ST_RMW_READ = 3'd2,
        ST_WRITE    = 3'd3,
        ST_RESP     = 3'd4
    } mau_state_e;

    // The reserved size is folded into misalignment so it takes the error path.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo_addr);
        logic mis;
        case (size)
            SIZE_BYTE: mis = 1'b0;
            SIZE_HALF: mis = lo_addr[0];
            SIZE_WORD: mis = (lo_addr != 2'b00);
            default:   mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: extracts/extends a sub-word from a memory word
// for loads and merges store data into that word for read-modify-write.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_word_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;

    assign byte_sh = {addr_i, 3'b000};
    assign half_sh = {addr_i[1], 4'b0000};

    always_comb begin
        byte_v       = word_i[byte_sh +: 8];
        half_v       = word_i[half_sh +: 16];
        load_data_o  = word_i;
        store_word_o = wdata_i;
        case (size_i)
            SIZE_BYTE: begin
                load_data_o  = {{24{byte_v[7] & ~unsigned_i}}, byte_v};
                store_word_o = word_i;
                store_word_o[byte_sh +: 8] = wdata_i[7:0];
            end
            SIZE_HALF: begin
                load_data_o  = {{16{half_v[15] & ~unsigned_i}}, half_v};
                store_word_o = word_i;
                store_word_o[half_sh +: 16] = wdata_i[15:0];
            end
            default: begin
                load_data_o  = word_i;
                store_word_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator side of the data-memory interface: turns byte/half/word loads and
// stores into word-aligned memRead/memWrite accesses behind a valid/ready port.
//
// Handshake: a request is accepted on a rising edge where req_valid && req_ready;
// req_ready is high only in IDLE. Memory completes a strobe on an edge where
// mem_ready is high; strobe, address and write data stay stable until then.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_writeData,
    output logic              mem_memRead,
    output logic              mem_memWrite,
    input  logic [31:0]       mem_readData,
    input  logic              mem_ready,
    output logic [2:0]        dbg_state_o
);

    mau_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              unsigned_q, unsigned_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [31:0]       wword_q, wword_d;

    logic        accept;
    logic        req_mis;
    logic [31:0] load_data;
    logic [31:0] store_word;

    assign accept  = (state_q == ST_IDLE) && req_valid;
    assign req_mis = is_misaligned(req_size, req_addr[1:0]);

    mem_lane_align u_lane (
        .word_i       (mem_readData),
        .addr_i       (addr_q[1:0]),
        .size_i       (size_q),
        .unsigned_i   (unsigned_q),
        .wdata_i      (wdata_q),
        .load_data_o  (load_data),
        .store_word_o (store_word)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_mis)                  state_d = ST_RESP;
                    else if (!req_write)          state_d = ST_READ;
                    else if (req_size == SIZE_WORD) state_d = ST_WRITE;
                    else                          state_d = ST_RMW_READ;
                end
            end
            ST_READ:     if (mem_ready) state_d = ST_RESP;
            ST_RMW_READ: if (mem_ready) state_d = ST_WRITE;
            ST_WRITE:    if (mem_ready) state_d = ST_RESP;
            ST_RESP:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Request capture, load result and write word; rdata starts at 0 so stores
    // and errors report zero data.
    always_comb begin
        addr_d     = addr_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        wword_d    = wword_q;
        if (accept) begin
            addr_d     = req_addr;
            size_d     = req_size;
            unsigned_d = req_unsigned;
            wdata_d    = req_wdata;
            rdata_d    = 32'h0;
            err_d      = req_mis;
            if (req_write && (req_size == SIZE_WORD) && !req_mis) wword_d = req_wdata;
        end
        if ((state_q == ST_READ) && mem_ready)     rdata_d = load_data;
        if ((state_q == ST_RMW_READ) && mem_ready) wword_d = store_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '0;
            size_q     <= SIZE_BYTE;
            unsigned_q <= 1'b0;
            wdata_q    <= 32'h0;
            rdata_q    <= 32'h0;
            err_q      <= 1'b0;
            wword_q    <= 32'h0;
        end else begin
            addr_q     <= addr_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            wword_q    <= wword_d;
        end
    end

    always_comb begin
        req_ready     = (state_q == ST_IDLE);
        resp_valid    = (state_q == ST_RESP);
        resp_rdata    = (state_q == ST_RESP) ? rdata_q : 32'h0;
        resp_err      = (state_q == ST_RESP) && err_q;
        mem_memRead   = (state_q == ST_READ) || (state_q == ST_RMW_READ);
        mem_memWrite  = (state_q == ST_WRITE);
        mem_address   = {addr_q[ADDR_W-1:2], 2'b00};
        mem_writeData = wword_q;
        dbg_state_o   = state_q;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit against a small word memory with a
// controllable mem_ready.
module tb_mem_access_unit;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [1:0]        req_size = 2'b00;
    logic              req_unsigned = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [31:0]       req_wdata = 32'h0;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_writeData;
    logic              mem_memRead;
    logic              mem_memWrite;
    logic [31:0]       mem_readData;
    logic              mem_ready = 1'b1;
    logic [2:0]        dbg_state;

    int n_assert = 0;
    int n_fail   = 0;
    int overlap  = 0;

    // clock / reset
    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .mem_address   (mem_address),
        .mem_writeData (mem_writeData),
        .mem_memRead   (mem_memRead),
        .mem_memWrite  (mem_memWrite),
        .mem_readData  (mem_readData),
        .mem_ready     (mem_ready),
        .dbg_state_o   (dbg_state)
    );

    // word memory: combinational read, write on a completing write strobe
    logic [31:0] mem [0:63];
    logic        pre_we = 1'b0;
    logic [5:0]  pre_idx = '0;
    logic [31:0] pre_data = 32'h0;

    assign mem_readData = mem[mem_address[7:2]];

    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_data;
        else if (mem_memWrite && mem_ready) mem[mem_address[7:2]] <= mem_writeData;
    end

    always @(negedge clk) begin
        if (mem_memRead && mem_memWrite) overlap++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [5:0] idx, input logic [31:0] data);
        pre_we = 1'b1; pre_idx = idx; pre_data = data;
        step();
        pre_we = 1'b0;
    endtask

    // Issue one request and follow it to its response, stalling the first
    // `low` access cycles with mem_ready low.
    task automatic run_req(input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd, input int low,
                           output int lat, output int rd_c, output int wr_c, output int rdy_hi,
                           output logic [31:0] rdata, output logic [31:0] wr_addr,
                           output logic [31:0] wr_data, output logic err);
        int left;
        left = low;
        lat = 1; rd_c = 0; wr_c = 0; rdy_hi = 0;
        wr_addr = 32'h0; wr_data = 32'h0;
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd; mem_ready = 1'b1;
        step();
        req_valid = 1'b0; req_write = ~wr; req_size = 2'b11; req_unsigned = ~uns;
        req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5555_5555;
        while (!resp_valid && lat < 40) begin
            if (mem_memRead) rd_c++;
            if (mem_memWrite) begin
                wr_c++;
                wr_addr = mem_address;
                wr_data = mem_writeData;
            end
            if (req_ready) rdy_hi++;
            if ((mem_memRead || mem_memWrite) && left > 0) begin
                mem_ready = 1'b0;
                left--;
            end else begin
                mem_ready = 1'b1;
            end
            step();
            lat++;
        end
        chk("resp_seen", 32'(resp_valid), 32'd1);
        rdata = resp_rdata;
        err = resp_err;
        mem_ready = 1'b1;
        step();
        chk("resp_single_pulse", 32'(resp_valid), 32'd0);
    endtask

    int          lat, rd_c, wr_c, rdy_hi, acc, pulses;
    logic [31:0] rdata, wr_addr, wr_data;
    logic        err;

    initial begin
        // reset and memory preload
        poke(6'd4, 32'h8899_AABB);
        poke(6'd8, 32'h0000_0000);
        step();
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_state", 32'(dbg_state), 32'd0);
        reset = 1'b0;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_err", 32'(resp_err), 32'd0);
        chk("rst_strobes", {30'b0, mem_memRead, mem_memWrite}, 32'd0);
        chk("rst_address", mem_address, 32'h0);
        chk("rst_wdata", mem_writeData, 32'h0);

        // lb 0x13 and lbu 0x12 on 0x8899AABB
        run_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 0, lat, rd_c, wr_c, rdy_hi, rdata, wr_addr, wr_data, err);
        chk("lb_rdata", rdata, 32'hFFFF_FF88);
        chk("lb_latency", 32'(lat), 32'd2);
        chk("lb_err", 32'(err), 32'd0);
        chk("lb_reads", 32'(rd_c), 32'd1);
        chk("lb_writes", 32'(wr_c), 32'd0);
        run_req(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 0, lat, rd_c, wr_c, rdy_hi, rdata, wr_addr, wr_data, err);
        chk("lbu_rdata", rdata, 32'h0000_0099);

        // sh 0x1234 at 0x12: one read, one write of the merged word
        run_req(1'b1, 2'b01, 1'b0, 32'h12, 32'hCAFE_1234, 0, lat, rd_c, wr_c, rdy_hi, rdata, wr_addr, wr_data, err);
        chk("sh_latency", 32'(lat), 32'd3);
        chk("sh_reads", 32'(rd_c), 32'd1);
        chk("sh_writes", 32'(wr_c), 32'd1);
        chk("sh_wdata", wr_data, 32'h1234_AABB);
        chk("sh_waddr", wr_addr, 32'h10);
        chk("sh_rdata", rdata, 32'h0);
        chk("sh_mem", mem[4], 32'h1234_AABB);

        // more loads on the merged word
        run_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 0, lat, rd_c, wr_c, rdy_hi, rdata, wr_addr, wr_data, err);
        chk("lh_rdata", rdata, 32'hFFFF_AABB);
        run_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 0, lat, rd_c, wr_c, rdy_hi, rdata, wr_addr, wr_data, err);
        chk("lhu_rdata", rdata, 32'h0000_1234);
        run_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 0, lat, rd_c, wr_c, rdy_hi, rdata, wr_addr, wr_data, err);
        chk("lb11_rdata", rdata, 32'hFFFF_FFAA);
        run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, lat, rd_c, wr_c, rdy_hi, rdata, wr_addr, wr_data, err);
        chk("lw_rdata", rdata, 32'h1234_AABB);

        // sb into byte 3 with one read stall
        run_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_0077, 1, lat, rd_c, wr_c, rdy_hi, rdata, wr_addr, wr_data, err);
        chk("sb_latency", 32'(lat), 32'd4);
        chk("sb_reads", 32'(rd_c), 32'd2);
        chk("sb_mem", mem[4], 32'h7734_AABB);

        // misaligned and reserved-size requests
        run_req(1'b0, 2'b10, 1'b0, 32'h0E, 32'h0, 0, lat, rd_c, wr_c, rdy_hi, rdata, wr_addr, wr_data, err);
        chk("mis_lw_err", 32'(err), 32'd1);
        chk("mis_lw_latency", 32'(lat), 32'd1);
        chk("mis_lw_rdata", rdata, 32'h0);
        chk("mis_lw_strobes", 32'(rd_c + wr_c), 32'd0);
        run_req(1'b1, 2'b01, 1'b0, 32'h11, 32'hFFFF_FFFF, 0, lat, rd_c, wr_c, rdy_hi, rdata, wr_addr, wr_data, err);
        chk("mis_sh_err", 32'(err), 32'd1);
        chk("mis_sh_strobes", 32'(rd_c + wr_c), 32'd0);
        chk("mis_sh_mem", mem[4], 32'h7734_AABB);
        run_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 0, lat, rd_c, wr_c, rdy_hi, rdata, wr_addr, wr_data, err);
        chk("rsvd_err", 32'(err), 32'd1);
        chk("rsvd_latency", 32'(lat), 32'd1);

        // sw with mem_ready low for 3 cycles
        run_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF, 3, lat, rd_c, wr_c, rdy_hi, rdata, wr_addr, wr_data, err);
        chk("sw_writes", 32'(wr_c), 32'd4);
        chk("sw_reads", 32'(rd_c), 32'd0);
        chk("sw_waddr", wr_addr, 32'h20);
        chk("sw_wdata", wr_data, 32'hDEAD_BEEF);
        chk("sw_latency", 32'(lat), 32'd5);
        chk("sw_ready_low", 32'(rdy_hi), 32'd0);
        chk("sw_err", 32'(err), 32'd0);
        chk("sw_mem", mem[8], 32'hDEAD_BEEF);

        // sb at 0x11, reset while waiting in RMW_READ
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h11; req_wdata = 32'h0000_0055; mem_ready = 1'b0;
        step();
        req_valid = 1'b0;
        chk("abort_rmw_state", 32'(dbg_state), 32'd2);
        chk("abort_read_strobe", 32'(mem_memRead), 32'd1);
        step();
        chk("abort_read_held", 32'(mem_memRead), 32'd1);
        chk("abort_read_addr", mem_address, 32'h10);
        reset = 1'b1;
        step();
        reset = 1'b0;
        mem_ready = 1'b1;
        chk("abort_state_idle", 32'(dbg_state), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_outputs", {29'b0, resp_valid, resp_err, mem_memRead | mem_memWrite}, 32'd0);
        chk("abort_rdata", resp_rdata, 32'h0);
        chk("abort_address", mem_address, 32'h0);
        chk("abort_wdata", mem_writeData, 32'h0);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            if (resp_valid || mem_memWrite) pulses++;
            step();
        end
        chk("abort_no_resp", 32'(pulses), 32'd0);
        chk("abort_mem", mem[4], 32'h7734_AABB);

        // req_valid held high: lw 0x20 repeatedly, one accept per IDLE cycle
        acc = 0; pulses = 0;
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h20; req_wdata = 32'h0;
        for (int i = 0; i < 9; i++) begin
            if (req_ready) acc++;
            if (resp_valid) begin
                pulses++;
                chk("b2b_rdata", resp_rdata, 32'hDEAD_BEEF);
            end
            step();
        end
        req_valid = 1'b0;
        chk("b2b_accepts", 32'(acc), 32'd3);
        chk("b2b_resps", 32'(pulses), 32'd3);
        step();
        step();
        chk("no_strobe_overlap", 32'(overlap), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
